// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the FIFO controller and its wrappers.
package fifo_ctrl_pkg;

    // Default geometry: a 1024-entry FIFO that flags "mostly full" at 75 %.
    localparam int DEFAULT_FIFO_DEPTH   = 1024;
    localparam int DEFAULT_ADDR_BITS    = 10;
    localparam int DEFAULT_AFULL_THRESH = 768;

    // Ceiling log2, used to size BRAM addresses from a depth that need not be a power of two.
    function automatic int fifo_clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'd1 << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping BRAM address pointer: counts 0..DEPTH-1 and wraps to 0, so a
// non-power-of-two depth never addresses entries beyond the FIFO.
module fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Next pointer: advance on inc, wrapping at the last valid entry.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a FIFO held in a dual-port BRAM. Drives the
// BRAM ports, tracks occupancy and keeps sticky overflow/underflow errors.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_BITS    = fifo_clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = DEFAULT_AFULL_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_req,
    input  logic                 rd_req,
    output logic                 bram_wr_en,
    output logic [ADDR_BITS-1:0] bram_wr_addr,
    output logic                 bram_rd_en,
    output logic [ADDR_BITS-1:0] bram_rd_addr,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 perc_full,
    output logic [ADDR_BITS:0]   usedw,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_BITS:0] DEPTH_CNT  = (ADDR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0] THRESH_CNT = (ADDR_BITS + 1)'(AFULL_THRESH);

    logic                 wr_acc;
    logic                 rd_acc;
    logic [1:0]           ptr_inc;
    logic [ADDR_BITS-1:0] ptr_val [2];

    logic [ADDR_BITS:0]   usedw_q,     usedw_d;
    logic                 full_q,      full_d;
    logic                 empty_q,     empty_d;
    logic                 perc_full_q, perc_full_d;
    logic                 rd_valid_q,  rd_valid_d;
    logic                 overflow_q,  overflow_d;
    logic                 underflow_q, underflow_d;

    // Accepts use this cycle's registered flags; reset masks them so the BRAM is never enabled in reset.
    assign wr_acc = en & wr_req & ~full_q  & ~rst;
    assign rd_acc = en & rd_req & ~empty_q & ~rst;

    // Index 0 is the write pointer, index 1 the read pointer.
    assign ptr_inc = {rd_acc, wr_acc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr #(
                .DEPTH (FIFO_DEPTH),
                .AW    (ADDR_BITS)
            ) u_ptr (
                .clk (clk),
                .rst (rst),
                .inc (ptr_inc[gi]),
                .ptr (ptr_val[gi])
            );
        end
    endgenerate

    // Occupancy and flags: flags derive from the next occupancy so they move on the same edge.
    always_comb begin
        usedw_d = usedw_q;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + (ADDR_BITS + 1)'(1);
            2'b01:   usedw_d = usedw_q - (ADDR_BITS + 1)'(1);
            default: usedw_d = usedw_q;
        endcase
        empty_d     = (usedw_d == '0);
        full_d      = (usedw_d == DEPTH_CNT);
        perc_full_d = (usedw_d >= THRESH_CNT);
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  | (en & wr_req & full_q);
        underflow_d = underflow_q | (en & rd_req & empty_q);
    end

    // State registers; reset discards any in-flight read so rd_valid stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            usedw_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            perc_full_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            usedw_q     <= usedw_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            perc_full_q <= perc_full_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bram_wr_en   = wr_acc;
    assign bram_rd_en   = rd_acc;
    assign bram_wr_addr = ptr_val[0];
    assign bram_rd_addr = ptr_val[1];
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign perc_full    = perc_full_q;
    assign usedw        = usedw_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: a 4-deep instance (threshold 3) for most
// scenarios and a 5-deep instance for non-power-of-two pointer wrap.
module tb_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: depth 4 ----------------
    logic       rst_a, en_a, wr_a, rd_a;
    logic       bwe_a, bre_a, rdv_a, full_a, empty_a, pf_a, ovf_a, unf_a;
    logic [1:0] wad_a, rad_a;
    logic [2:0] used_a;

    fifo_ctrl #(.FIFO_DEPTH(4), .ADDR_BITS(2), .AFULL_THRESH(3)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .wr_req(wr_a), .rd_req(rd_a),
        .bram_wr_en(bwe_a), .bram_wr_addr(wad_a), .bram_rd_en(bre_a), .bram_rd_addr(rad_a),
        .rd_valid(rdv_a), .full(full_a), .empty(empty_a), .perc_full(pf_a), .usedw(used_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    // ---------------- DUT B: depth 5 ----------------
    logic       rst_b, en_b, wr_b, rd_b;
    logic       bwe_b, bre_b, rdv_b, full_b, empty_b, pf_b, ovf_b, unf_b;
    logic [2:0] wad_b, rad_b;
    logic [3:0] used_b;

    fifo_ctrl #(.FIFO_DEPTH(5), .ADDR_BITS(3), .AFULL_THRESH(3)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .wr_req(wr_b), .rd_req(rd_b),
        .bram_wr_en(bwe_b), .bram_wr_addr(wad_b), .bram_rd_en(bre_b), .bram_rd_addr(rad_b),
        .rd_valid(rdv_b), .full(full_b), .empty(empty_b), .perc_full(pf_b), .usedw(used_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; prints one line per cycle of the 4-deep instance.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("cyc rst=%0b en=%0b wr=%0b rd=%0b usedw=%0d wa=%0d ra=%0d full=%0b empty=%0b rdv=%0b ovf=%0b unf=%0b",
                 rst_a, en_a, wr_a, rd_a, used_a, wad_a, rad_a, full_a, empty_a, rdv_a, ovf_a, unf_a);
    endtask

    task automatic reset_a();
        rst_a = 1'b1; wr_a = 1'b0; rd_a = 1'b0;
        tick();
        rst_a = 1'b0;
    endtask

    // Expected address sequences for the depth-5 wrap test.
    int exp_addr5 [7] = '{0, 1, 2, 3, 4, 0, 1};

    initial begin
        rst_a = 1'b1; en_a = 1'b1; wr_a = 1'b1; rd_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1; wr_b = 1'b0; rd_b = 1'b0;

        // 1: reset; enables must stay low while reset is held, even with requests.
        #1;
        check_val("rst_wr_en", 32'(bwe_a), 0);
        check_val("rst_rd_en", 32'(bre_a), 0);
        tick();
        tick();
        check_val("rst_empty", 32'(empty_a), 1);
        check_val("rst_full", 32'(full_a), 0);
        check_val("rst_pfull", 32'(pf_a), 0);
        check_val("rst_usedw", 32'(used_a), 0);
        check_val("rst_rdvalid", 32'(rdv_a), 0);
        check_val("rst_ovf", 32'(ovf_a), 0);
        check_val("rst_unf", 32'(unf_a), 0);
        check_val("rst_waddr", 32'(wad_a), 0);
        check_val("rst_raddr", 32'(rad_a), 0);
        rst_a = 1'b0; rst_b = 1'b0; wr_a = 1'b0; rd_a = 1'b0;

        // 2: five writes; the fifth is rejected and flags overflow.
        for (int i = 0; i < 5; i++) begin
            wr_a = 1'b1;
            #1;
            check_val($sformatf("w%0d_wr_en", i), 32'(bwe_a), (i < 4) ? 1 : 0);
            check_val($sformatf("w%0d_waddr", i), 32'(wad_a), (i < 4) ? i : 0);
            tick();
            check_val($sformatf("w%0d_usedw", i), 32'(used_a), (i < 4) ? i + 1 : 4);
            check_val($sformatf("w%0d_pfull", i), 32'(pf_a), (i >= 2) ? 1 : 0);
            check_val($sformatf("w%0d_full", i), 32'(full_a), (i >= 3) ? 1 : 0);
            check_val($sformatf("w%0d_ovf", i), 32'(ovf_a), (i == 4) ? 1 : 0);
        end
        wr_a = 1'b0;

        // 3: five reads from full; the fifth is rejected and flags underflow.
        for (int i = 0; i < 5; i++) begin
            rd_a = 1'b1;
            #1;
            check_val($sformatf("r%0d_rd_en", i), 32'(bre_a), (i < 4) ? 1 : 0);
            check_val($sformatf("r%0d_raddr", i), 32'(rad_a), (i < 4) ? i : 0);
            check_val($sformatf("r%0d_rdv_pre", i), 32'(rdv_a), (i > 0) ? 1 : 0);
            tick();
            check_val($sformatf("r%0d_rdv", i), 32'(rdv_a), (i < 4) ? 1 : 0);
            check_val($sformatf("r%0d_usedw", i), 32'(used_a), (i < 4) ? 3 - i : 0);
            check_val($sformatf("r%0d_empty", i), 32'(empty_a), (i >= 3) ? 1 : 0);
            check_val($sformatf("r%0d_unf", i), 32'(unf_a), (i == 4) ? 1 : 0);
        end
        rd_a = 1'b0;

        // 4a: simultaneous access at usedw=2.
        reset_a();
        wr_a = 1'b1;
        tick();
        tick();
        rd_a = 1'b1;
        #1;
        check_val("s2_wr_en", 32'(bwe_a), 1);
        check_val("s2_rd_en", 32'(bre_a), 1);
        check_val("s2_waddr", 32'(wad_a), 2);
        check_val("s2_raddr", 32'(rad_a), 0);
        tick();
        check_val("s2_usedw", 32'(used_a), 2);
        check_val("s2_waddr_nxt", 32'(wad_a), 3);
        check_val("s2_raddr_nxt", 32'(rad_a), 1);
        check_val("s2_rdv", 32'(rdv_a), 1);

        // 4b: fill, then simultaneous access while full.
        rd_a = 1'b0;
        tick();
        tick();
        check_val("sf_full", 32'(full_a), 1);
        check_val("sf_wrap_waddr", 32'(wad_a), 1);
        rd_a = 1'b1;
        #1;
        check_val("sf_wr_en", 32'(bwe_a), 0);
        check_val("sf_rd_en", 32'(bre_a), 1);
        tick();
        check_val("sf_usedw", 32'(used_a), 3);
        check_val("sf_ovf", 32'(ovf_a), 1);
        check_val("sf_full_after", 32'(full_a), 0);
        check_val("sf_unf", 32'(unf_a), 0);

        // 4c: simultaneous access while empty: no fall-through.
        reset_a();
        wr_a = 1'b1; rd_a = 1'b1;
        #1;
        check_val("se_wr_en", 32'(bwe_a), 1);
        check_val("se_rd_en", 32'(bre_a), 0);
        tick();
        check_val("se_usedw", 32'(used_a), 1);
        check_val("se_rdv", 32'(rdv_a), 0);
        check_val("se_unf", 32'(unf_a), 1);
        check_val("se_ovf", 32'(ovf_a), 0);
        check_val("se_empty", 32'(empty_a), 0);

        // 6a: en low with both requests for three cycles holds all state.
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("en0_%0d_wr_en", i), 32'(bwe_a), 0);
            check_val($sformatf("en0_%0d_rd_en", i), 32'(bre_a), 0);
            tick();
            check_val($sformatf("en0_%0d_usedw", i), 32'(used_a), 1);
            check_val($sformatf("en0_%0d_waddr", i), 32'(wad_a), 1);
            check_val($sformatf("en0_%0d_raddr", i), 32'(rad_a), 0);
            check_val($sformatf("en0_%0d_rdv", i), 32'(rdv_a), 0);
            check_val($sformatf("en0_%0d_ovf", i), 32'(ovf_a), 0);
        end
        en_a = 1'b1;

        // 6b: reset in the middle of a read burst at usedw=3.
        rd_a = 1'b0;
        tick();
        tick();
        check_val("rb_usedw3", 32'(used_a), 3);
        wr_a = 1'b0; rd_a = 1'b1;
        tick();
        check_val("rb_rdv1", 32'(rdv_a), 1);
        rst_a = 1'b1;
        tick();
        check_val("rb_usedw", 32'(used_a), 0);
        check_val("rb_empty", 32'(empty_a), 1);
        check_val("rb_rdv", 32'(rdv_a), 0);
        check_val("rb_unf", 32'(unf_a), 0);
        rst_a = 1'b0; rd_a = 1'b0;

        // 5: depth 5, seven writes interleaved with seven reads; pointers wrap 4->0.
        for (int i = 0; i < 7; i++) begin
            wr_b = 1'b1; rd_b = 1'b0;
            #1;
            check_val($sformatf("d5_w%0d_waddr", i), 32'(wad_b), 32'(exp_addr5[i]));
            check_val($sformatf("d5_w%0d_wr_en", i), 32'(bwe_b), 1);
            tick();
            check_val($sformatf("d5_w%0d_usedw", i), 32'(used_b), 1);
            wr_b = 1'b0; rd_b = 1'b1;
            #1;
            check_val($sformatf("d5_r%0d_raddr", i), 32'(rad_b), 32'(exp_addr5[i]));
            check_val($sformatf("d5_r%0d_rd_en", i), 32'(bre_b), 1);
            tick();
            check_val($sformatf("d5_r%0d_usedw", i), 32'(used_b), 0);
            check_val($sformatf("d5_r%0d_rdv", i), 32'(rdv_b), 1);
        end
        rd_b = 1'b0;
        check_val("d5_final_waddr", 32'(wad_b), 2);
        check_val("d5_final_raddr", 32'(rad_b), 2);
        check_val("d5_unf", 32'(unf_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
